// File: rtl/object_slot_arbiter_pkg.sv
// Shared sizes and object type codes for the gamedata object-slot table.
// Type codes match the values the gamedata writer stores in each slot.
package object_slot_arbiter_pkg;
    localparam int NSLOT   = 8;
    localparam int NREQ    = 3;
    localparam int TYPELEN = 3;
    localparam int IDXW    = $clog2(NSLOT);
    localparam int RPW     = $clog2(NREQ);

    typedef enum logic [TYPELEN-1:0] {
        OBJ_EMPTY = 3'd0,
        OBJ_ENEMY = 3'd1,
        OBJ_CLOUD = 3'd2,
        OBJ_BONUS = 3'd3
    } obj_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/object_slot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick
    import object_slot_arbiter_pkg::*;
#(
    parameter int N  = NREQ,
    parameter int PW = RPW
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] winner_o,
    output logic          any_o
);
    int idx;

    // Scan farthest-first so the candidate nearest ptr_i is the last to overwrite.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (req_i[idx]) begin
                winner_o = idx[PW-1:0];
                any_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/object_slot_arbiter.sv
// Round-robin arbiter handing out free gamedata object slots to spawners,
// with a busy bitmap, lowest-free-slot allocation and a retire (free) port.
module object_slot_arbiter
    import object_slot_arbiter_pkg::*;
(
    input  logic                    clk3,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*TYPELEN-1:0] req_type,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         fail,
    output logic [IDXW-1:0]         gnt_slot,
    output logic                    wr_en,
    output logic [IDXW-1:0]         wr_slot,
    output logic [TYPELEN-1:0]      wr_type,
    input  logic                    free_valid,
    input  logic [IDXW-1:0]         free_slot,
    output logic [NSLOT-1:0]        slot_busy,
    output logic                    full
);
    state_e               state_q, state_d;
    logic [RPW-1:0]       rr_q, rr_d, winner_q, winner_d, pick;
    logic                 pick_any;
    logic [NSLOT-1:0]     busy_q, busy_d, free_vec, avail;
    logic                 avail_any;
    logic [IDXW-1:0]      low_idx;
    logic [NREQ-1:0]      gnt_q, gnt_d, fail_q, fail_d;
    logic [IDXW-1:0]      gslot_q, gslot_d, wslot_q, wslot_d;
    logic [TYPELEN-1:0]   wtype_q, wtype_d;
    logic                 wr_en_q, wr_en_d;

    rr_pick #(.N(NREQ), .PW(RPW)) u_pick (
        .req_i    (req),
        .ptr_i    (rr_q),
        .winner_o (pick),
        .any_o    (pick_any)
    );

    // Out-of-range free_slot matches no bit, so it is silently ignored.
    always_comb begin
        free_vec = '0;
        for (int i = 0; i < NSLOT; i++)
            free_vec[i] = free_valid && (free_slot == IDXW'(i));
    end

    // Same-edge free is applied before looking for a free slot.
    assign avail     = ~(busy_q & ~free_vec);
    assign avail_any = |avail;

    always_comb begin
        low_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--)
            if (avail[i]) low_idx = IDXW'(i);
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        winner_d = winner_q;
        busy_d   = busy_q & ~free_vec;
        gnt_d    = '0;
        fail_d   = '0;
        wr_en_d  = 1'b0;
        gslot_d  = gslot_q;
        wslot_d  = wslot_q;
        wtype_d  = wtype_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_ALLOC;
                    winner_d = pick;
                end
            end
            ST_ALLOC: begin
                state_d = ST_DONE;
                rr_d    = (winner_q == RPW'(NREQ - 1)) ? '0 : winner_q + 1'b1;
                if (avail_any) begin
                    busy_d[low_idx] = 1'b1;
                    gnt_d[winner_q] = 1'b1;
                    gslot_d         = low_idx;
                    wr_en_d         = 1'b1;
                    wslot_d         = low_idx;
                    wtype_d         = req_type[winner_q*TYPELEN +: TYPELEN];
                end else begin
                    fail_d[winner_q] = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Restart aborts anything in flight, including a same-edge allocation.
        if (clear) begin
            state_d = ST_IDLE;
            busy_d  = '0;
            rr_d    = '0;
            gnt_d   = '0;
            fail_d  = '0;
            wr_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            winner_q <= '0;
            busy_q   <= '0;
            gnt_q    <= '0;
            fail_q   <= '0;
            wr_en_q  <= 1'b0;
            gslot_q  <= '0;
            wslot_q  <= '0;
            wtype_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            winner_q <= winner_d;
            busy_q   <= busy_d;
            gnt_q    <= gnt_d;
            fail_q   <= fail_d;
            wr_en_q  <= wr_en_d;
            gslot_q  <= gslot_d;
            wslot_q  <= wslot_d;
            wtype_q  <= wtype_d;
        end
    end

    assign gnt       = gnt_q;
    assign fail      = fail_q;
    assign gnt_slot  = gslot_q;
    assign wr_en     = wr_en_q;
    assign wr_slot   = wslot_q;
    assign wr_type   = wtype_q;
    assign slot_busy = busy_q;
    assign full      = &busy_q;
endmodule

// File: tb/tb_object_slot_arbiter.sv
// Directed bench for object_slot_arbiter: allocation order, table-full fail,
// same-edge free/alloc, synchronous clear and asynchronous reset.
module tb_object_slot_arbiter;
    import object_slot_arbiter_pkg::*;

    logic                    clk3 = 1'b0;
    logic                    rst_n, clear, free_valid;
    logic [NREQ-1:0]         req;
    logic [NREQ*TYPELEN-1:0] req_type;
    logic [IDXW-1:0]         free_slot;
    logic [NREQ-1:0]         gnt, fail;
    logic [IDXW-1:0]         gnt_slot, wr_slot;
    logic                    wr_en, full;
    logic [TYPELEN-1:0]      wr_type;
    logic [NSLOT-1:0]        slot_busy;

    int total = 0;
    int bad   = 0;

    object_slot_arbiter dut (
        .clk3       (clk3),
        .rst_n      (rst_n),
        .clear      (clear),
        .req        (req),
        .req_type   (req_type),
        .gnt        (gnt),
        .fail       (fail),
        .gnt_slot   (gnt_slot),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .wr_type    (wr_type),
        .free_valid (free_valid),
        .free_slot  (free_slot),
        .slot_busy  (slot_busy),
        .full       (full)
    );

    always #5 clk3 = ~clk3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk3);
        #1;
    endtask

    // Drive a request from IDLE and stop in the DONE cycle (two edges later).
    task automatic alloc(input logic [NREQ-1:0] r);
        req = r;
        step();
        step();
    endtask

    // Drop the request during DONE and return to IDLE.
    task automatic finish_req();
        req = '0;
        step();
    endtask

    int exp_w [5] = '{0, 1, 2, 0, 1};

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        free_valid = 1'b0;
        free_slot  = '0;
        req        = '0;
        req_type   = {OBJ_BONUS, OBJ_CLOUD, OBJ_ENEMY};
        #12;
        chk("rst_gnt",  32'(gnt), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_wren", 32'(wr_en), 0);
        chk("rst_busy", 32'(slot_busy), 0);
        chk("rst_full", 32'(full), 0);
        @(negedge clk3);
        rst_n = 1'b1;
        step();

        // 1: single enemy request, two-edge latency
        req = 3'b001;
        step();
        chk("t1_lat_gnt",  32'(gnt), 0);
        chk("t1_lat_wren", 32'(wr_en), 0);
        step();
        chk("t1_gnt",    32'(gnt), 32'h1);
        chk("t1_slot",   32'(gnt_slot), 0);
        chk("t1_wren",   32'(wr_en), 1);
        chk("t1_wslot",  32'(wr_slot), 0);
        chk("t1_wtype",  32'(wr_type), 32'(OBJ_ENEMY));
        chk("t1_busy",   32'(slot_busy), 32'h01);
        finish_req();
        chk("t1_pulse_clr", 32'(gnt), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_busy", 32'(slot_busy), 0);

        // 2: all three requesting continuously, round-robin from 0
        req = 3'b111;
        for (int g = 0; g < 5; g++) begin
            step();
            step();
            chk($sformatf("t2_gnt%0d", g),  32'(gnt), 32'(1 << exp_w[g]));
            chk($sformatf("t2_slot%0d", g), 32'(gnt_slot), 32'(g));
            if (g == 4) req = '0;
            step();
        end
        chk("t2_busy", 32'(slot_busy), 32'h1F);

        // 3: fill slots 5..7, then table-full fails
        alloc(3'b100);
        chk("t3_gnt5",   32'(gnt), 32'h4);
        chk("t3_slot5",  32'(gnt_slot), 5);
        chk("t3_type5",  32'(wr_type), 32'(OBJ_BONUS));
        finish_req();
        alloc(3'b001);
        chk("t3_slot6",  32'(gnt_slot), 6);
        finish_req();
        alloc(3'b001);
        chk("t3_slot7",  32'(gnt_slot), 7);
        finish_req();
        chk("t3_full",   32'(full), 1);
        alloc(3'b010);
        chk("t3_fail",   32'(fail), 32'h2);
        chk("t3_nognt",  32'(gnt), 0);
        chk("t3_nowr",   32'(wr_en), 0);
        chk("t3_busyFF", 32'(slot_busy), 32'hFF);
        finish_req();
        alloc(3'b111);
        chk("t3_rr2_fail", 32'(fail), 32'h4);
        finish_req();

        // 4: free slot 5 on the ALLOC edge, same slot reallocated
        req = 3'b001;
        step();
        free_valid = 1'b1;
        free_slot  = 3'd5;
        step();
        free_valid = 1'b0;
        chk("t4_gnt",  32'(gnt), 32'h1);
        chk("t4_slot", 32'(gnt_slot), 5);
        chk("t4_busy", 32'(slot_busy), 32'hFF);
        finish_req();
        free_valid = 1'b1;
        free_slot  = 3'd3;
        step();
        chk("t4_free3", 32'(slot_busy), 32'hF7);
        chk("t4_notfull", 32'(full), 0);
        step();
        free_valid = 1'b0;
        chk("t4_free_idle", 32'(slot_busy), 32'hF7);

        // 5: clear during ALLOC aborts the grant
        req = 3'b010;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        req   = '0;
        chk("t5_gnt",  32'(gnt), 0);
        chk("t5_wren", 32'(wr_en), 0);
        chk("t5_busy", 32'(slot_busy), 0);
        step();
        chk("t5_idle_gnt", 32'(gnt), 0);
        alloc(3'b111);
        chk("t5_rr0_gnt",  32'(gnt), 32'h1);
        chk("t5_rr0_slot", 32'(gnt_slot), 0);
        finish_req();

        // 6: asynchronous reset in the middle of DONE
        alloc(3'b100);
        chk("t6_pre_gnt", 32'(gnt), 32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_gnt",   32'(gnt), 0);
        chk("t6_wren",  32'(wr_en), 0);
        chk("t6_busy",  32'(slot_busy), 0);
        chk("t6_gslot", 32'(gnt_slot), 0);
        chk("t6_wtype", 32'(wr_type), 0);
        req = '0;
        @(negedge clk3);
        rst_n = 1'b1;
        step();
        alloc(3'b010);
        chk("t6_post_gnt",  32'(gnt), 32'h2);
        chk("t6_post_slot", 32'(gnt_slot), 0);
        chk("t6_post_type", 32'(wr_type), 32'(OBJ_CLOUD));
        finish_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
